leitor_hexa: RTL and testbench
==============================

LEITOR_HEXA -- requirements
Module: leitor_hexa

Interface
- REQ-001 The block SHALL have one clock and an asynchronous active-low reset, named CLK and RST_N.
- REQ-002 Parameter STABLE_CYC, default 4, range 2..255: number of consecutive identical samples needed to accept a digit.
- REQ-003 CLK  input  1  rising-edge clock for all state.
- REQ-004 RST_N  input  1  asynchronous active-low reset.
- REQ-005 SEG  input  7  active-high segment bus, bit order {G,F,E,D,C,B,A}.
- REQ-006 DIG  input  2  digit enable: 2'b01 selects the low-nibble display, 2'b10 the high-nibble display; 00 and 11 mean blank.
- REQ-007 BIN  output  8  decoded byte {high nibble, low nibble}.
- REQ-008 OUT_VALID  output  1  BIN holds an unconsumed byte.
- REQ-009 OUT_READY  input  1  consumer accepts BIN when OUT_VALID and OUT_READY are both high at a rising edge.
- REQ-010 ERR  output  1  qualifies BIN; high when either digit pattern was not in the decode table.
- REQ-011 OVF  output  1  one-cycle pulse: an unconsumed byte was overwritten.

Function
- REQ-012 SEG patterns SHALL decode as: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71 (hex). Any other pattern SHALL decode to nibble 0 with an invalid flag.
- REQ-013 Stability counter: it SHALL increment while DIG is one-hot and DIG and SEG both equal their values on the previous cycle. It SHALL reload to 1 on any change. It SHALL reload to 0 while DIG is 00 or 11.
- REQ-014 A digit SHALL be latched (nibble and invalid flag) at the edge where the counter reaches STABLE_CYC. At most one latch SHALL occur per dwell. The counter SHALL saturate until DIG or SEG changes.
- REQ-015 Capture FSM states: IDLE (no digit held), HAVE_LO, HAVE_HI.
  - IDLE: a low latch goes to HAVE_LO; a high latch goes to HAVE_HI.
  - HAVE_LO: a new low latch overwrites the held low nibble and stays in HAVE_LO; a high latch completes the byte and goes to IDLE.
  - HAVE_HI: symmetric to HAVE_LO.
- REQ-016 On completion, BIN, ERR and OUT_VALID SHALL update on the next rising edge. Latency is 1 cycle from the second digit latch.
- REQ-017 OUT_VALID SHALL stay high, and BIN and ERR SHALL stay stable, until the byte is accepted.
- REQ-018 On acceptance with no completion pending, OUT_VALID SHALL fall on that edge.
- REQ-019 Completion with OUT_VALID=1 and OUT_READY=0: BIN and ERR SHALL take the new byte, OUT_VALID SHALL remain 1, and OVF SHALL pulse for 1 cycle.
- REQ-020 Completion in the same cycle as an acceptance: the old byte is consumed, the new byte is presented on the next cycle with OUT_VALID continuously high, and no OVF.
- REQ-021 OUT_READY SHALL be ignored while OUT_VALID=0.
- REQ-022 A blank DIG SHALL NOT clear held nibbles or FSM state. Only reset clears them.

Reset
- REQ-023 While RST_N=0, the following SHALL be forced asynchronously:
  - BIN=8'h00, OUT_VALID=0, ERR=0, OVF=0;
  - FSM=IDLE, stability counter=0, previous-sample registers=0, held nibbles=0.
- REQ-024 Reset asserted mid-dwell or mid-frame SHALL discard partial captures. After release, a full STABLE_CYC dwell SHALL be needed for each digit.
- REQ-025 The first capture after release SHALL be evaluated from the first rising edge at which RST_N=1.

Verification
- REQ-026 Basic frame: STABLE_CYC=4, OUT_READY=1, SEG=6D with DIG=01 for 4 cycles, then SEG=7C with DIG=10 for 4 cycles -> BIN=8'hB5, ERR=0, OUT_VALID high for exactly 1 cycle, 1 cycle after the 4th high-digit sample.
- REQ-027 Short dwell: DIG=01 with SEG=06 for 3 cycles, then DIG=00 -> no latch and FSM stays IDLE. A following 4-cycle dwell with SEG=06 latches low nibble 1.
- REQ-028 Invalid pattern: low SEG=7F, high SEG=12 (4 cycles each) -> BIN=8'h08, ERR=1.
- REQ-029 Backpressure: OUT_READY=0, frames 0x3A then 0x91 -> OVF pulses once, and BIN=8'h91 with OUT_VALID=1 held. Raising OUT_READY for 1 cycle drops OUT_VALID.
- REQ-030 Reset mid-frame: low digit latched, then RST_N pulsed low for 1 cycle -> all outputs 0 and FSM IDLE. A high-only dwell afterwards produces no byte.
- REQ-031 Simultaneous accept and complete: OUT_VALID=1, and OUT_READY=1 in the cycle the second digit latches -> OUT_VALID stays high, BIN changes to the new byte on the next cycle, and OVF=0.

Source files
------------

// File: rtl/leitor_hexa.sv
// leitor_hexa: debounces a two-digit multiplexed 7-segment bus and assembles the decoded hex byte
module leitor_hexa #(
    parameter int STABLE_CYC = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [6:0] SEG,
    input  logic [1:0] DIG,
    input  logic       OUT_READY,
    output logic [7:0] BIN,
    output logic       OUT_VALID,
    output logic       ERR,
    output logic       OVF
);
    typedef enum logic [1:0] {IDLE, HAVE_LO, HAVE_HI} state_t;

    localparam logic [7:0] LIM = 8'(STABLE_CYC);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [6:0] prev_seg_q, prev_seg_d;
    logic [1:0] prev_dig_q, prev_dig_d;
    logic [3:0] lo_q, lo_d, hi_q, hi_d;
    logic       lo_inv_q, lo_inv_d, hi_inv_q, hi_inv_d;
    logic [7:0] bin_q, bin_d;
    logic       valid_q, valid_d, err_q, err_d, ovf_q, ovf_d;
    logic       one_hot, same, latch, lo_lat, hi_lat, complete;
    logic [4:0] dec;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h3F: decode = 5'h00;
            7'h06: decode = 5'h01;
            7'h5B: decode = 5'h02;
            7'h4F: decode = 5'h03;
            7'h66: decode = 5'h04;
            7'h6D: decode = 5'h05;
            7'h7D: decode = 5'h06;
            7'h07: decode = 5'h07;
            7'h7F: decode = 5'h08;
            7'h6F: decode = 5'h09;
            7'h77: decode = 5'h0A;
            7'h7C: decode = 5'h0B;
            7'h39: decode = 5'h0C;
            7'h5E: decode = 5'h0D;
            7'h79: decode = 5'h0E;
            7'h71: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    // Stability counter: a digit latches exactly once, on the sample that brings the count to LIM
    always_comb begin
        one_hot    = (DIG == 2'b01) || (DIG == 2'b10);
        same       = (DIG == prev_dig_q) && (SEG == prev_seg_q);
        cnt_d      = !one_hot ? 8'd0 : !same ? 8'd1 : (cnt_q == LIM) ? cnt_q : cnt_q + 8'd1;
        latch      = one_hot && same && (cnt_q == LIM - 8'd1);
        lo_lat     = latch && DIG[0];
        hi_lat     = latch && DIG[1];
        prev_seg_d = SEG;
        prev_dig_d = DIG;
        dec        = decode(SEG);
    end

    // Capture FSM: holds one nibble until its partner arrives, then hands the byte to the output stage
    always_comb begin
        state_d  = state_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        lo_inv_d = lo_inv_q;
        hi_inv_d = hi_inv_q;
        complete = 1'b0;
        if (lo_lat) begin
            lo_d     = dec[3:0];
            lo_inv_d = dec[4];
            complete = (state_q == HAVE_HI);
            state_d  = complete ? IDLE : HAVE_LO;
        end
        if (hi_lat) begin
            hi_d     = dec[3:0];
            hi_inv_d = dec[4];
            complete = (state_q == HAVE_LO);
            state_d  = complete ? IDLE : HAVE_HI;
        end
    end

    // Output stage: a new byte always wins; overflow only when the old byte was not taken on that edge
    always_comb begin
        valid_d = complete || (valid_q && !OUT_READY);
        bin_d   = complete ? {hi_d, lo_d} : bin_q;
        err_d   = complete ? (hi_inv_d || lo_inv_d) : err_q;
        ovf_d   = complete && valid_q && !OUT_READY;
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prev_seg_q <= '0;
            prev_dig_q <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            lo_inv_q   <= 1'b0;
            hi_inv_q   <= 1'b0;
            bin_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_seg_q <= prev_seg_d;
            prev_dig_q <= prev_dig_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            lo_inv_q   <= lo_inv_d;
            hi_inv_q   <= hi_inv_d;
            bin_q      <= bin_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
        end
    end

    assign BIN       = bin_q;
    assign OUT_VALID = valid_q;
    assign ERR       = err_q;
    assign OVF       = ovf_q;
endmodule

// File: tb/tb_leitor_hexa.sv
// tb_leitor_hexa: directed checks of digit debouncing, byte assembly, backpressure and reset
module tb_leitor_hexa;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [6:0] SEG = '0;
    logic [1:0] DIG = '0;
    logic       OUT_READY = 1'b0;
    logic [7:0] BIN;
    logic       OUT_VALID, ERR, OVF;
    int         errs = 0;
    int         checks = 0;

    leitor_hexa #(.STABLE_CYC(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .SEG(SEG), .DIG(DIG), .OUT_READY(OUT_READY),
        .BIN(BIN), .OUT_VALID(OUT_VALID), .ERR(ERR), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [6:0] s, input logic [1:0] d);
        SEG = s;
        DIG = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic dwell(input logic [6:0] s, input logic [1:0] d, input int n);
        repeat (n) step(s, d);
    endtask

    initial begin
        #12;
        chk("rst_bin", BIN, 8'h00);
        chk("rst_valid", 8'(OUT_VALID), 8'd0);
        chk("rst_err", 8'(ERR), 8'd0);
        chk("rst_ovf", 8'(OVF), 8'd0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        OUT_READY = 1'b1;
        dwell(7'h6D, 2'b01, 4);
        chk("basic_lo_only", 8'(OUT_VALID), 8'd0);
        dwell(7'h7C, 2'b10, 3);
        chk("basic_early", 8'(OUT_VALID), 8'd0);
        step(7'h7C, 2'b10);
        chk("basic_valid", 8'(OUT_VALID), 8'd1);
        chk("basic_bin", BIN, 8'hB5);
        chk("basic_err", 8'(ERR), 8'd0);
        step(7'h00, 2'b00);
        chk("basic_one_cycle", 8'(OUT_VALID), 8'd0);

        dwell(7'h06, 2'b01, 3);
        step(7'h06, 2'b00);
        dwell(7'h7C, 2'b10, 4);
        chk("short_no_latch", 8'(OUT_VALID), 8'd0);
        dwell(7'h06, 2'b01, 4);
        chk("short_then_full_valid", 8'(OUT_VALID), 8'd1);
        chk("short_then_full_bin", BIN, 8'hB1);
        step(7'h00, 2'b00);

        dwell(7'h3F, 2'b01, 4);
        dwell(7'h4F, 2'b01, 4);
        dwell(7'h66, 2'b10, 4);
        chk("lo_overwrite_bin", BIN, 8'h43);
        step(7'h00, 2'b00);

        dwell(7'h06, 2'b01, 4);
        dwell(7'h07, 2'b10, 10);
        chk("sat_dropped", 8'(OUT_VALID), 8'd0);
        dwell(7'h3F, 2'b01, 4);
        chk("sat_single_latch", 8'(OUT_VALID), 8'd0);
        dwell(7'h7F, 2'b10, 4);
        chk("sat_next_bin", BIN, 8'h80);
        step(7'h00, 2'b00);

        dwell(7'h6F, 2'b10, 4);
        dwell(7'h00, 2'b00, 3);
        dwell(7'h3F, 2'b01, 4);
        chk("blank_keeps_bin", BIN, 8'h90);
        step(7'h00, 2'b00);

        dwell(7'h7F, 2'b01, 4);
        dwell(7'h12, 2'b10, 4);
        chk("invalid_bin", BIN, 8'h08);
        chk("invalid_err", 8'(ERR), 8'd1);
        step(7'h00, 2'b00);

        OUT_READY = 1'b0;
        dwell(7'h77, 2'b01, 4);
        dwell(7'h4F, 2'b10, 4);
        chk("bp_first_bin", BIN, 8'h3A);
        chk("bp_first_err", 8'(ERR), 8'd0);
        chk("bp_first_ovf", 8'(OVF), 8'd0);
        dwell(7'h06, 2'b01, 4);
        chk("bp_held_valid", 8'(OUT_VALID), 8'd1);
        chk("bp_held_bin", BIN, 8'h3A);
        dwell(7'h6F, 2'b10, 4);
        chk("bp_ovf_pulse", 8'(OVF), 8'd1);
        chk("bp_new_bin", BIN, 8'h91);
        chk("bp_valid", 8'(OUT_VALID), 8'd1);
        step(7'h6F, 2'b10);
        chk("bp_ovf_end", 8'(OVF), 8'd0);
        chk("bp_still_valid", 8'(OUT_VALID), 8'd1);
        OUT_READY = 1'b1;
        step(7'h00, 2'b00);
        chk("bp_accept", 8'(OUT_VALID), 8'd0);

        OUT_READY = 1'b0;
        dwell(7'h6D, 2'b01, 4);
        dwell(7'h5B, 2'b10, 4);
        chk("sim_old_bin", BIN, 8'h25);
        dwell(7'h7D, 2'b01, 4);
        dwell(7'h07, 2'b10, 3);
        OUT_READY = 1'b1;
        step(7'h07, 2'b10);
        chk("sim_valid", 8'(OUT_VALID), 8'd1);
        chk("sim_bin", BIN, 8'h76);
        chk("sim_no_ovf", 8'(OVF), 8'd0);
        step(7'h00, 2'b00);
        chk("sim_accept", 8'(OUT_VALID), 8'd0);

        OUT_READY = 1'b0;
        dwell(7'h06, 2'b01, 4);
        dwell(7'h06, 2'b10, 4);
        chk("rstm_pre_bin", BIN, 8'h11);
        dwell(7'h3F, 2'b01, 4);
        SEG = 7'h00;
        DIG = 2'b00;
        #2;
        RST_N = 1'b0;
        #1;
        chk("rstm_bin", BIN, 8'h00);
        chk("rstm_valid", 8'(OUT_VALID), 8'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        dwell(7'h7F, 2'b10, 4);
        chk("rstm_hi_only", 8'(OUT_VALID), 8'd0);
        dwell(7'h06, 2'b01, 4);
        chk("rstm_after_bin", BIN, 8'h81);
        chk("rstm_after_valid", 8'(OUT_VALID), 8'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
